// File: rtl/cdb_broadcaster.sv
// ============================================================================
// cdb_broadcaster : round-robin collector of functional-unit results that
//                   drives the registered common data bus {tag, data}.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module cdb_broadcaster #(
  parameter int NUM_SRC = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src,
  output logic                      err_tag0,
  output logic [15:0]               bcast_cnt
);

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_SRC - 1);

  // Holding entries
  logic [NUM_SRC-1:0]        occ_q, occ_d;
  logic [NUM_SRC*TAG_W-1:0]  hold_tag_q, hold_tag_d;
  logic [NUM_SRC*DATA_W-1:0] hold_data_q, hold_data_d;
  logic [SRC_W-1:0]          ptr_q, ptr_d;

  // Broadcast register and status
  logic                      cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]          cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]         cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]          cdb_src_q, cdb_src_d;
  logic                      err_tag0_q, err_tag0_d;
  logic [15:0]               bcast_cnt_q, bcast_cnt_d;

  // Arbitration and handshake
  logic [NUM_SRC-1:0]        hi_req;
  logic [NUM_SRC-1:0]        grant;
  logic                      gnt_valid;
  logic [SRC_W-1:0]          gnt_idx;
  logic [NUM_SRC-1:0]        tag_nz;
  logic [NUM_SRC-1:0]        accept;
  logic [TAG_W-1:0]          win_tag;
  logic [DATA_W-1:0]         win_data;

  // Round-robin: prefer the lowest occupied index at or above ptr, else wrap
  // to the lowest occupied index overall.
  always_comb begin
    hi_req    = '0;
    grant     = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hi_req[i] = occ_q[i] && (i >= int'(ptr_q));
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!gnt_valid && hi_req[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_W'(i);
        grant[i]  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!gnt_valid && occ_q[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_W'(i);
        grant[i]  = 1'b1;
      end
    end
  end

  // Winner payload via one-hot OR mux
  always_comb begin
    win_tag  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        win_tag  = win_tag  | hold_tag_q[i*TAG_W +: TAG_W];
        win_data = win_data | hold_data_q[i*DATA_W +: DATA_W];
      end
    end
  end

  // A granted entry frees its slot this edge, so the source may refill it.
  assign src_ready = ~{NUM_SRC{flush}} & (~occ_q | grant);

  always_comb begin
    tag_nz = '0;
    accept = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      tag_nz[i] = |src_tag[i*TAG_W +: TAG_W];
      accept[i] = src_valid[i] & src_ready[i];
    end
  end

  always_comb begin
    occ_d       = occ_q;
    hold_tag_d  = hold_tag_q;
    hold_data_d = hold_data_q;
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    bcast_cnt_d = bcast_cnt_q;
    // accept is already zero on a flush edge
    err_tag0_d  = err_tag0_q | (|(accept & ~tag_nz));

    if (flush) begin
      occ_d = '0;
      ptr_d = '0;
    end else begin
      occ_d = (occ_q & ~grant) | (accept & tag_nz);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i] && tag_nz[i]) begin
          hold_tag_d[i*TAG_W +: TAG_W]    = src_tag[i*TAG_W +: TAG_W];
          hold_data_d[i*DATA_W +: DATA_W] = src_data[i*DATA_W +: DATA_W];
        end
      end
      if (gnt_valid) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = win_tag;
        cdb_data_d  = win_data;
        cdb_src_d   = gnt_idx;
        ptr_d       = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + SRC_W'(1);
        bcast_cnt_d = bcast_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q       <= '0;
      hold_tag_q  <= '0;
      hold_data_q <= '0;
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      err_tag0_q  <= 1'b0;
      bcast_cnt_q <= '0;
    end else begin
      occ_q       <= occ_d;
      hold_tag_q  <= hold_tag_d;
      hold_data_q <= hold_data_d;
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      err_tag0_q  <= err_tag0_d;
      bcast_cnt_q <= bcast_cnt_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign err_tag0  = err_tag0_q;
  assign bcast_cnt = bcast_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_broadcaster.sv
// ============================================================================
// tb_cdb_broadcaster : directed self-checking bench for cdb_broadcaster.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_cdb_broadcaster;

  localparam int NUM_SRC = 4;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;
  localparam int SRC_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      flush;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;
  logic                      err_tag0;
  logic [15:0]               bcast_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  cdb_broadcaster #(
    .NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W), .SRC_W(SRC_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .err_tag0  (err_tag0),
    .bcast_cnt (bcast_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d);
    src_valid[i]                = v;
    src_tag[i*TAG_W +: TAG_W]   = t;
    src_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_valid"}, 32'(cdb_valid), 32'd0);
    check({pfx, "_tag"},   32'(cdb_tag),   32'd0);
    check({pfx, "_data"},  cdb_data,       32'd0);
    check({pfx, "_src"},   32'(cdb_src),   32'd0);
    check({pfx, "_err"},   32'(err_tag0),  32'd0);
    check({pfx, "_cnt"},   32'(bcast_cnt), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    src_tag   = '0;
    src_data  = '0;

    // Reset state
    step(); step();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step();

    // Single result from src 2: visible 2 edges after the handshake
    set_src(2, 1'b1, 4'd5, 32'hDEADBEEF);
    #1 check("single_ready", 32'(src_ready), 32'hF);
    step();
    src_valid = '0;
    check("single_lat1_valid", 32'(cdb_valid), 32'd0);
    step();
    check("single_valid", 32'(cdb_valid), 32'd1);
    check("single_tag",   32'(cdb_tag),   32'd5);
    check("single_data",  cdb_data,       32'hDEADBEEF);
    check("single_src",   32'(cdb_src),   32'd2);
    check("single_cnt",   32'(bcast_cnt), 32'd1);
    step();
    check("single_pulse", 32'(cdb_valid), 32'd0);
    check("single_hold_tag", 32'(cdb_tag), 32'd5);

    // Flush returns ptr to 0 (ptr is 3 after src 2 won)
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_cnt", 32'(bcast_cnt), 32'd1);

    // All four sources streaming tags 1..4
    for (int i = 0; i < NUM_SRC; i++)
      set_src(i, 1'b1, 4'(i + 1), 32'h1111_1111 * (i + 1));
    step();
    check("rr_ready_fill", 32'(src_ready), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_valid", 32'(cdb_valid), 32'd1);
      check("rr_tag",   32'(cdb_tag),   32'((k % 4) + 1));
      check("rr_src",   32'(cdb_src),   32'(k % 4));
      check("rr_data",  cdb_data,       32'h1111_1111 * ((k % 4) + 1));
      check("rr_ready", 32'(src_ready), 32'(1 << ((k + 1) % 4)));
    end
    src_valid = '0;
    repeat (5) step();
    check("rr_drained", 32'(cdb_valid), 32'd0);
    check("rr_cnt",     32'(bcast_cnt), 32'd11);

    // Tag 0 on src 1: accepted, dropped, sticky error
    set_src(1, 1'b1, 4'd0, 32'h1234_5678);
    #1 check("tag0_ready", 32'(src_ready[1]), 32'd1);
    step();
    src_valid = '0;
    check("tag0_err",     32'(err_tag0),  32'd1);
    check("tag0_nobcast", 32'(cdb_valid), 32'd0);
    step();
    check("tag0_nobcast2", 32'(cdb_valid), 32'd0);
    check("tag0_cnt",      32'(bcast_cnt), 32'd11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("tag0_err_after_flush", 32'(err_tag0), 32'd1);

    // Flush squashes held tags 7 and 9
    set_src(0, 1'b1, 4'd7, 32'h0000_0007);
    set_src(3, 1'b1, 4'd9, 32'h0000_0009);
    step();
    src_valid = '0;
    flush     = 1'b1;
    #1 check("flush_ready", 32'(src_ready), 32'd0);
    step();
    flush = 1'b0;
    check("flush_valid", 32'(cdb_valid), 32'd0);
    step();
    check("flush_valid2", 32'(cdb_valid), 32'd0);
    check("flush_cnt2",   32'(bcast_cnt), 32'd11);
    // ptr back at 0: src 1 and src 3 loaded together, src 1 wins first
    set_src(1, 1'b1, 4'd7, 32'h0000_0077);
    set_src(3, 1'b1, 4'd9, 32'h0000_0099);
    step();
    src_valid = '0;
    step();
    check("ptr0_first_tag", 32'(cdb_tag), 32'd7);
    check("ptr0_first_src", 32'(cdb_src), 32'd1);
    step();
    check("ptr0_second_tag", 32'(cdb_tag), 32'd9);
    check("ptr0_second_src", 32'(cdb_src), 32'd3);
    step();
    check("ptr0_cnt", 32'(bcast_cnt), 32'd13);

    // Back-to-back stream 3,4,5 from src 1
    set_src(1, 1'b1, 4'd3, 32'h0000_0003);
    step();
    set_src(1, 1'b1, 4'd4, 32'h0000_0004);
    step();
    check("stream_t3", 32'(cdb_tag), 32'd3);
    check("stream_v3", 32'(cdb_valid), 32'd1);
    set_src(1, 1'b1, 4'd5, 32'h0000_0005);
    step();
    check("stream_t4", 32'(cdb_tag), 32'd4);
    check("stream_v4", 32'(cdb_valid), 32'd1);
    src_valid = '0;
    step();
    check("stream_t5", 32'(cdb_tag), 32'd5);
    check("stream_v5", 32'(cdb_valid), 32'd1);
    step();
    check("stream_end", 32'(cdb_valid), 32'd0);
    check("stream_cnt", 32'(bcast_cnt), 32'd16);

    // Counter wrap: stream from src 0 until 0xFFFF, then one more
    set_src(0, 1'b1, 4'd1, 32'hCAFE_0000);
    step();
    repeat (65519) @(posedge clk);
    #1;
    check("wrap_ffff", 32'(bcast_cnt), 32'hFFFF);
    step();
    check("wrap_zero", 32'(bcast_cnt), 32'd0);
    check("wrap_valid", 32'(cdb_valid), 32'd1);

    // Reset mid-stream with an entry held; reset dominates flush
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    check_zero_outputs("midrst");
    rst_n     = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    step();
    check("midrst_nobcast1", 32'(cdb_valid), 32'd0);
    step();
    check("midrst_nobcast2", 32'(cdb_valid), 32'd0);
    check("midrst_cnt",      32'(bcast_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Producer end of the tag-clearing protocol consumed by the register rename table and the reservation stations.
- Collects completed results from NUM_SRC functional units. Each unit has a valid/ready handshake and a one-entry holding register.
- A round-robin arbiter selects one held result per cycle. The selected result is broadcast on the registered common data bus (CDB) as {tag, data}.
- Consumers compare cdb_tag against their stored names and clear/capture on a match. Tag 0 means "value valid, no producer" and is never broadcast.

Parameters:
- NUM_SRC, 4, number of functional-unit result sources (2..8).
- TAG_W, 4, reservation-station tag width; tag 0 reserved.
- DATA_W, 32, result data width.
- SRC_W, 2, width of source index, equal to clog2(NUM_SRC).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous squash of all held and pending results
- src_valid  in  NUM_SRC  per-source result valid
- src_tag  in  NUM_SRC*TAG_W  per-source tag; source i is at [i*TAG_W +: TAG_W]
- src_data  in  NUM_SRC*DATA_W  per-source result; source i is at [i*DATA_W +: DATA_W]
- src_ready  out  NUM_SRC  per-source accept
- cdb_valid  out  1  broadcast valid, one-cycle pulse per result
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast value
- cdb_src  out  SRC_W  index of the winning source
- err_tag0  out  1  sticky: a tag-0 result was offered
- bcast_cnt  out  16  number of broadcasts since reset, wraps at 0xFFFF->0

Behaviour:
- Reset: rst_n is synchronous, active-low, sampled on the rising edge of clk.
  - Outputs after reset: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, err_tag0=0, bcast_cnt=0.
  - Internal state after reset: all holding entries empty, round-robin pointer=0.
  - Reset mid-operation discards every held entry with no broadcast.
- Handshake: source i transfers on a rising edge where src_valid[i] & src_ready[i]=1.
  - src_ready[i] = ~flush & (~occ[i] | grant[i]). This is combinational, so a source that wins every cycle can stream at 1 result/cycle.
  - Payload is captured into hold_tag[i]/hold_data[i]; occ[i] is set.
  - src_valid without ready: the source must hold its payload stable. The block never drops such a payload.
- Tag 0: an offered tag-0 result is accepted (ready per the rule above) and discarded, so occ is not set. err_tag0 sets on the following edge and holds until reset; flush does not clear it.
- Arbitration is combinational on occ[].
  - Search order starts at ptr, then ptr+1, ... modulo NUM_SRC.
  - The first occupied entry wins: grant is one-hot, or zero if no entry is occupied.
  - On a grant, ptr <= winner+1 mod NUM_SRC. With no grant, ptr is unchanged.
- Broadcast register: on the grant edge, cdb_valid<=1, cdb_tag<=hold_tag[w], cdb_data<=hold_data[w], cdb_src<=w, occ[w] is cleared unless refilled the same edge, and bcast_cnt increments.
  - With no grant: cdb_valid<=0, and tag/data/src hold their previous values.
- Latency: a handshake at edge E0 holds the entry after E0. If it wins at E1, cdb_valid is high during the cycle after E1. Minimum latency is 2 edges.
- No CDB backpressure: every consumer must accept cdb_valid in a single cycle.
- Simultaneous events:
  - Grant and refill of the same source on the same edge: the old entry broadcasts and the new entry is held.
  - Flush together with rst_n low: reset dominates.
- flush (sampled on the edge):
  - Clears all occ and sets cdb_valid<=0. ptr<=0.
  - No handshake completes on a flush edge (src_ready=0).
  - bcast_cnt does not increment on a flush edge.
- Starvation bound: an occupied source broadcasts within NUM_SRC grant cycles.

Test Plan:
- Reset then single result: src_valid[2]=1, tag=5, data=0xDEADBEEF for 1 cycle. Required: cdb_valid=1 exactly 2 edges later for 1 cycle with tag=5, data=0xDEADBEEF, src=2; bcast_cnt=1.
- All 4 sources valid continuously with tags 1,2,3,4, ptr=0. Required: broadcast order 1,2,3,4,1,2,... with cdb_valid high every cycle; each src_ready is high only in that source's grant cycle after the first fill.
- Tag 0 offered on src 1. Required: src_ready[1]=1, no broadcast, err_tag0=1 from the next cycle; err_tag0 stays 1 after flush and clears only on rst_n=0.
- Sources 0 and 3 hold entries (tags 7, 9), ptr=0, and flush is asserted for 1 cycle. Required: no broadcast of 7 or 9, cdb_valid=0 the next cycle, src_ready=0 during the flush cycle, ptr=0 afterwards.
- Source 1 streams tags 3,4,5 back-to-back with the other sources idle. Required: cdb_tag sequence 3,4,5 on 3 consecutive cycles with no bubble.
- Force bcast_cnt to 0xFFFF via 65535 broadcasts, then one more. Required: bcast_cnt=0; assert rst_n=0 mid-stream with entries held, and required: all outputs 0 and no broadcast afterwards.
